latch_monitor: RTL and testbench

LATCH_MONITOR -- requirements
Module: latch_monitor

---
 rtl/latch_monitor_pkg.sv | 32 +++
 rtl/latch_monitor_settle_counter.sv | 56 +++++
 rtl/latch_monitor.sv | 92 +++++++++
 tb/tb_latch_monitor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/latch_monitor_pkg.sv
// ============================================================================
// Module : latch_monitor_pkg
// Brief  : State encodings, counter widths and saturating helpers for latch_monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package latch_monitor_pkg;

    localparam int c_settle_w  = 4;
    localparam int c_timeout_w = 8;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_armed  = 3'd1;
    localparam logic [2:0] c_st_report = 3'd2;
    localparam logic [2:0] c_st_done   = 3'd3;
    localparam logic [2:0] c_st_fail   = 3'd4;

    localparam logic [c_settle_w-1:0]  c_settle_one  = 4'd1;
    localparam logic [c_timeout_w-1:0] c_timeout_one = 8'd1;

    function automatic logic [c_settle_w-1:0] sat_inc_settle(input logic [c_settle_w-1:0] v);
        return (&v) ? v : v + c_settle_one;
    endfunction

    function automatic logic [c_timeout_w-1:0] sat_inc_timeout(input logic [c_timeout_w-1:0] v);
        return (&v) ? v : v + c_timeout_one;
    endfunction

endpackage

`default_nettype wire

// File: rtl/latch_monitor_settle_counter.sv
// ============================================================================
// Module : settle_counter
// Brief  : One-deep sample history and saturating count of repeated nonzero samples.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module settle_counter
    import latch_monitor_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_data,
    output logic             settled
);

    localparam logic [c_settle_w-1:0] c_settle = c_settle_w'(SETTLE);

    logic [WIDTH-1:0]      r_history;
    logic [c_settle_w-1:0] r_count;
    logic [c_settle_w-1:0] w_count_next;
    logic                  w_nonzero;

    assign w_nonzero = |in_data;

    always_comb begin
        w_count_next = '0;
        if (w_nonzero) begin
            w_count_next = (in_data == r_history) ? sat_inc_settle(r_count) : c_settle_one;
        end
    end

    // Settled is judged on the count this edge would load, so the FSM can leave on the same edge.
    assign settled = enable && (w_count_next >= c_settle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_history <= '0;
            r_count   <= '0;
        end else if (clear) begin
            r_history <= '0;
            r_count   <= '0;
        end else if (enable) begin
            r_history <= in_data;
            r_count   <= w_count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/latch_monitor.sv
// ============================================================================
// Module : latch_monitor
// Brief  : Waits for a latched bus to settle on a nonzero value and reports it once.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module latch_monitor
    import latch_monitor_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             arm,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [WIDTH-1:0] rpt_data,
    output logic             done,
    output logic             timed_out
);

    localparam logic [c_timeout_w-1:0] c_timeout = c_timeout_w'(TIMEOUT);

    logic [2:0]             r_state;
    logic [c_timeout_w-1:0] r_tmo_count;
    logic [WIDTH-1:0]       r_rpt_data;
    logic [c_timeout_w-1:0] w_tmo_next;
    logic                   w_tmo_expired;
    logic                   w_settled;

    settle_counter #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) u_settle_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (r_state == c_st_idle),
        .enable  (r_state == c_st_armed),
        .in_data (in_data),
        .settled (w_settled)
    );

    assign w_tmo_next    = sat_inc_timeout(r_tmo_count);
    assign w_tmo_expired = (w_tmo_next >= c_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_tmo_count <= '0;
            r_rpt_data  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_tmo_count <= '0;
                    if (arm) begin
                        r_state <= c_st_armed;
                    end
                end
                c_st_armed: begin
                    r_tmo_count <= w_tmo_next;
                    // A settle on the expiry edge still counts as a success.
                    if (w_settled) begin
                        r_state    <= c_st_report;
                        r_rpt_data <= in_data;
                    end else if (w_tmo_expired) begin
                        r_state <= c_st_fail;
                    end
                end
                c_st_report: begin
                    if (rpt_ready) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: r_state <= c_st_done;
                c_st_fail: r_state <= c_st_fail;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign rpt_valid = (r_state == c_st_report);
    assign rpt_data  = r_rpt_data;
    assign done      = (r_state == c_st_done);
    assign timed_out = (r_state == c_st_fail);

endmodule

`default_nettype wire

// File: tb/tb_latch_monitor.sv
// ============================================================================
// Module : tb_latch_monitor
// Brief  : Directed vectors and corner sequences for latch_monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_latch_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_data;
    logic       arm;
    logic       rpt_ready;

    // A: SETTLE=2 TIMEOUT=8, B: SETTLE=2 TIMEOUT=4, C: SETTLE=1 TIMEOUT=8
    logic       a_valid, b_valid, c_valid;
    logic [1:0] a_data, b_data, c_data;
    logic       a_done, b_done, c_done;
    logic       a_to, b_to, c_to;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    latch_monitor #(.WIDTH(2), .SETTLE(2), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .arm(arm),
        .rpt_valid(a_valid), .rpt_ready(rpt_ready), .rpt_data(a_data),
        .done(a_done), .timed_out(a_to)
    );

    latch_monitor #(.WIDTH(2), .SETTLE(2), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .arm(arm),
        .rpt_valid(b_valid), .rpt_ready(rpt_ready), .rpt_data(b_data),
        .done(b_done), .timed_out(b_to)
    );

    latch_monitor #(.WIDTH(2), .SETTLE(1), .TIMEOUT(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .arm(arm),
        .rpt_valid(c_valid), .rpt_ready(rpt_ready), .rpt_data(c_data),
        .done(c_done), .timed_out(c_to)
    );

    typedef struct packed {
        logic       do_reset;
        logic       arm;
        logic [1:0] in_data;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_data;
        logic       exp_done;
        logic       exp_to;
    } vec_t;

    localparam int N_VEC = 16;
    vec_t vecs [0:N_VEC-1];

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        arm       = 1'b0;
        in_data   = 2'b00;
        rpt_ready = 1'b0;
        step();
        check1("rst a_valid", a_valid, 1'b0);
        check2("rst a_data", a_data, 2'b00);
        check1("rst a_done", a_done, 1'b0);
        check1("rst a_to", a_to, 1'b0);
        check1("rst b_valid", b_valid, 1'b0);
        check1("rst c_valid", c_valid, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          rst   arm   in     rdy   val   data   done  to
        vecs[0]  = {1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1]  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[2]  = {1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[3]  = {1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
        vecs[4]  = {1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0};
        vecs[5]  = {1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0};
        vecs[6]  = {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[7]  = {1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[8]  = {1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[9]  = {1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[10] = {1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[11] = {1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[12] = {1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[13] = {1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[14] = {1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[15] = {1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1};

        apply_reset();

        // Settle-and-accept, then alternating data running into the timeout (instance A)
        for (int i = 0; i < N_VEC; i++) begin
            if (vecs[i].do_reset) apply_reset();
            arm       = vecs[i].arm;
            in_data   = vecs[i].in_data;
            rpt_ready = vecs[i].ready;
            step();
            check1($sformatf("vec%0d valid", i), a_valid, vecs[i].exp_valid);
            check2($sformatf("vec%0d data", i), a_data, vecs[i].exp_data);
            check1($sformatf("vec%0d done", i), a_done, vecs[i].exp_done);
            check1($sformatf("vec%0d timed_out", i), a_to, vecs[i].exp_to);
        end

        // Settle on the same edge as timeout expiry (instance B, TIMEOUT=4)
        apply_reset();
        arm = 1'b1; in_data = 2'b00; step();
        arm = 1'b0; step();
        step();
        in_data = 2'b11; step();
        check1("tie pre valid", b_valid, 1'b0);
        check1("tie pre to", b_to, 1'b0);
        step();
        check1("tie valid", b_valid, 1'b1);
        check1("tie to", b_to, 1'b0);
        check2("tie data", b_data, 2'b11);

        // SETTLE=1: first nonzero sample reports (instance C)
        apply_reset();
        arm = 1'b1; in_data = 2'b00; step();
        check1("s1 armed valid", c_valid, 1'b0);
        arm = 1'b0; in_data = 2'b10; step();
        check1("s1 valid", c_valid, 1'b1);
        check2("s1 data", c_data, 2'b10);
        check1("s1 a not settled", a_valid, 1'b0);

        // Backpressure: report held stable while in_data moves
        apply_reset();
        arm = 1'b1; step();
        arm = 1'b0; in_data = 2'b11; step();
        step();
        check1("bp valid0", a_valid, 1'b1);
        for (int k = 0; k < 20; k++) begin
            in_data = 2'($urandom_range(0, 3));
            step();
            check1($sformatf("bp%0d valid", k), a_valid, 1'b1);
            check2($sformatf("bp%0d data", k), a_data, 2'b11);
        end
        rpt_ready = 1'b1; step();
        check1("bp done", a_done, 1'b1);
        check1("bp valid after", a_valid, 1'b0);
        rpt_ready = 1'b0;

        // Asynchronous reset mid-cycle in REPORT aborts the session
        apply_reset();
        arm = 1'b1; step();
        arm = 1'b0; in_data = 2'b11; step();
        step();
        check1("ar pre valid", a_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1("ar valid async", a_valid, 1'b0);
        check2("ar data async", a_data, 2'b00);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check1($sformatf("ar idle%0d valid", k), a_valid, 1'b0);
            check1($sformatf("ar idle%0d done", k), a_done, 1'b0);
        end
        arm = 1'b1; step();
        arm = 1'b0; step();
        check1("ar rearm cnt1", a_valid, 1'b0);
        step();
        check1("ar rearm valid", a_valid, 1'b1);
        check2("ar rearm data", a_data, 2'b11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
